adc_sample_fifo: RTL and testbench

//  Downstream stage of the SPI ADC receiver. Detects each new-sample strobe, captures the 12-bit two's-complement word and converts it to a left-justified signed OUT_W sample.

---
 rtl/adc_sample_pkg.sv | 28 ++
 rtl/adc_sample_fifo_sync_fifo.sv | 66 ++++++
 rtl/adc_sample_fifo.sv | 102 ++++++++++
 tb/tb_adc_sample_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_sample_pkg.sv
// adc_sample_pkg: shared widths, sample type and arithmetic helpers for the
// ADC sample front end.
//   ADC_IN_W / ADC_OUT_W : default ADC word and output sample widths
//   sample_t             : signed output sample
//   justify()            : left-justify a two's-complement ADC word into sample_t
//   sat()                : clamp a wide signed value into sample_t (DC blocker)
package adc_sample_pkg;

  localparam int ADC_IN_W  = 12;
  localparam int ADC_OUT_W = 16;
  // Width of the intermediate fed to sat(); must cover the DC accumulator.
  localparam int SAT_W     = 32;
  localparam int SMAX      = 2 ** (ADC_OUT_W - 1) - 1;

  typedef logic signed [ADC_OUT_W-1:0] sample_t;

  // Low bits zero-filled; the sign bit lands in the MSB so sign is kept.
  function automatic sample_t justify(input logic [ADC_IN_W-1:0] w);
    return sample_t'({w, {(ADC_OUT_W - ADC_IN_W){1'b0}}});
  endfunction

  function automatic sample_t sat(input logic signed [SAT_W-1:0] v);
    if (v > SMAX)            return sample_t'(SMAX);
    else if (v < -SMAX - 1)  return sample_t'(-SMAX - 1);
    else                     return v[ADC_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/adc_sample_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered head word.
//   clock, reset : posedge clock, synchronous active-high reset
//   push, din    : write request/data (ignored when full unless popping)
//   pop          : consume head (ignored when empty)
//   dout         : registered head, 0 when empty
//   level        : occupancy 0..DEPTH
//   full, empty  : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic [LW-1:0]    lvl_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             pop_ok, push_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    rd_nxt  = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
    lvl_nxt = level;
    if (push_ok && !pop_ok)      lvl_nxt = level + LW'(1);
    else if (pop_ok && !push_ok) lvl_nxt = level - LW'(1);
    // Head register looks one cycle ahead; bypass din when the word being
    // written is the one that becomes head (empty or single-entry FIFO).
    if (lvl_nxt == '0)                    head_nxt = '0;
    else if (push_ok && rd_nxt == wr_ptr) head_nxt = din;
    else                                  head_nxt = mem[rd_nxt];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_nxt;
      level  <= lvl_nxt;
      dout   <= head_nxt;
    end
  end

endmodule

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: captures ADC samples on the rising edge of adc_ready,
// left-justifies them to OUT_W, buffers them and hands them to the effects
// chain over valid/ready.
//   clock, reset          : posedge clock, synchronous active-high reset
//   adc_datos, adc_ready  : ADC word and new-sample level flag
//   out_data, out_valid,
//   out_ready             : FIFO head handshake
//   level                 : FIFO occupancy
//   overflow, clear_ovf   : sticky drop flag and its clear pulse
// Build option: define DC_BLOCK_EN to insert a first-order DC blocker in the
// capture stage (time constant 2^DC_SHIFT samples); otherwise samples pass
// straight through.
module adc_sample_fifo
  import adc_sample_pkg::*;
#(
  parameter int IN_W  = ADC_IN_W,
  parameter int OUT_W = ADC_OUT_W,
  parameter int DEPTH = 16
`ifdef DC_BLOCK_EN
  ,
  parameter int DC_SHIFT = 10
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [IN_W-1:0]        adc_datos,
  input  logic                   adc_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clear_ovf
);

  logic    ready_q, cap, stage_vld, pop, drop, full, empty;
  sample_t stage, y;

  // ready_q resets low, so a level already high after reset is a new edge.
  assign cap = adc_ready & ~ready_q;

`ifdef DC_BLOCK_EN
  localparam int ACC_W = OUT_W + DC_SHIFT + 1;
  logic signed [ACC_W-1:0] acc, avg, diff;
  sample_t                 x;

  // acc tracks 2^DC_SHIFT times the running mean; subtracting acc/2^DC_SHIFT
  // removes DC while the error term feeds the tracker.
  always_comb begin
    x    = justify(adc_datos);
    avg  = acc >>> DC_SHIFT;
    diff = ACC_W'(x) - avg;
    y    = sat(SAT_W'(diff));
  end

  always_ff @(posedge clock) begin
    if (reset)    acc <= '0;
    else if (cap) acc <= acc + diff;
  end
`else
  always_comb y = justify(adc_datos);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q   <= 1'b0;
      stage     <= '0;
      stage_vld <= 1'b0;
    end else begin
      ready_q   <= adc_ready;
      stage_vld <= cap;
      if (cap) stage <= y;
    end
  end

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign drop      = stage_vld & full & ~pop;

  // A drop wins over a same-cycle clear so no loss goes unreported.
  always_ff @(posedge clock) begin
    if (reset)          overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (stage_vld),
    .pop   (pop),
    .din   (stage),
    .dout  (out_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_adc_sample_fifo.sv
module tb_adc_sample_fifo;

  localparam int DEPTH = 16;
  localparam int DCS   = 4;

  logic        clock = 1'b0;
  logic        reset, adc_ready, out_ready, clear_ovf;
  logic [11:0] adc_datos;
  logic [15:0] out_data;
  logic        out_valid, overflow;
  logic [4:0]  level;

  int vectors = 0;
  int errs    = 0;

  // Reference model state
  logic [15:0] q[$];
  logic [15:0] pend;
  bit          pend_vld, prev_rdy, m_ovf;
  longint      acc;

  always #5 clock = ~clock;

  adc_sample_fifo #(
    .DEPTH (DEPTH)
`ifdef DC_BLOCK_EN
    ,
    .DC_SHIFT (DCS)
`endif
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .adc_datos (adc_datos),
    .adc_ready (adc_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  // Expected output sample: signed ADC value times 2^(16-12), then the
  // optional DC removal in plain integer arithmetic.
  function automatic logic [15:0] model_y(input logic [11:0] d);
    longint s, xv, yv;
    s  = d[11] ? longint'(d) - 4096 : longint'(d);
    xv = s * 16;
    yv = xv;
`ifdef DC_BLOCK_EN
    begin
      longint avg, dlt;
      avg = acc >>> DCS;
      dlt = xv - avg;
      acc = acc + dlt;
      yv  = (dlt > 32767) ? 32767 : (dlt < -32768) ? -32768 : dlt;
    end
`endif
    return 16'(yv);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, step the model with the inputs seen at that edge,
  // then compare every output.
  task automatic cycle();
    bit was_full, popd, dropped;
    @(posedge clock);
    #1;
    if (reset) begin
      q.delete();
      pend_vld = 0;
      prev_rdy = 0;
      m_ovf    = 0;
      acc      = 0;
    end else begin
      was_full = (q.size() == DEPTH);
      popd     = (q.size() > 0) && out_ready;
      dropped  = 0;
      if (popd) void'(q.pop_front());
      if (pend_vld) begin
        if (!was_full || popd) q.push_back(pend);
        else dropped = 1;
      end
      if (dropped)        m_ovf = 1;
      else if (clear_ovf) m_ovf = 0;
      pend_vld = adc_ready && !prev_rdy;
      if (pend_vld) pend = model_y(adc_datos);
      prev_rdy = adc_ready;
    end
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("out_data",  32'(out_data),  (q.size() > 0) ? 32'(q[0]) : 32'h0);
    chk("level",     32'(level),     32'(q.size()));
    chk("overflow",  32'(overflow),  32'(m_ovf));
  endtask

  task automatic strobe(input logic [11:0] d);
    adc_datos = d;
    adc_ready = 1;
    cycle();
    adc_ready = 0;
    cycle();
  endtask

  task automatic do_reset();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  initial begin
    reset = 1; adc_ready = 0; adc_datos = '0; out_ready = 0; clear_ovf = 0;
    pend = '0; pend_vld = 0; prev_rdy = 0; m_ovf = 0; acc = 0;

    // Reset state
    cycle(); cycle();
    reset = 0;
    cycle();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data),  0);

    // Held level gives one capture, 2-clock latency
    adc_datos = 12'h123; adc_ready = 1;
    cycle();
    cycle();
    chk("lat_valid", 32'(out_valid), 1);
    repeat (8) cycle();
    adc_ready = 0;
    cycle();
`ifndef DC_BLOCK_EN
    chk("held_data", 32'(out_data), 32'h1230);
    // Sign boundaries of left-justification
    do_reset();
    out_ready = 1;
    strobe(12'h800);
    chk("neg_full", 32'(out_data), 32'h8000);
    strobe(12'h7FF);
    chk("pos_full", 32'(out_data), 32'h7FF0);
    out_ready = 0;
`endif
    chk("held_level", 32'(level), 1);

    // Fill to 16, 17th dropped, clear
    do_reset();
    for (int i = 0; i < 17; i++) strobe(12'($urandom));
    chk("full_level", 32'(level), 16);
    chk("full_ovf",   32'(overflow), 1);
    clear_ovf = 1;
    cycle();
    clear_ovf = 0;
    chk("clr_ovf", 32'(overflow), 0);

    // Full FIFO, push coincides with pop
    adc_datos = 12'($urandom); adc_ready = 1;
    cycle();
    adc_ready = 0; out_ready = 1;
    cycle();
    out_ready = 0;
    chk("fullpp_level", 32'(level), 16);
    chk("fullpp_ovf",   32'(overflow), 0);

    // Counting strobes with random backpressure, pointers wrap
    do_reset();
    for (int v = 1; v <= 64; v++) begin
      adc_datos = 12'(v); adc_ready = 1; out_ready = 1'($urandom);
      cycle();
      adc_ready = 0; out_ready = 1'($urandom);
      cycle();
    end
    out_ready = 1;
    repeat (40) cycle();
    chk("drain_level", 32'(level), 0);

    // Random traffic with a reset in the middle
    for (int i = 0; i < 400; i++) begin
      adc_ready = ($urandom_range(2, 0) == 0);
      adc_datos = 12'($urandom);
      out_ready = ($urandom_range(3, 0) == 0);
      clear_ovf = ($urandom_range(19, 0) == 0);
      reset     = (i == 200);
      cycle();
    end
    reset = 0; clear_ovf = 0; adc_ready = 0;

`ifdef DC_BLOCK_EN
    // Constant input decays toward zero
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 200; i++) strobe(12'h100);
    chk("dc_small", 32'(($signed(out_data) < 16) && ($signed(out_data) > -16) ? 1 : 0), 1);
    out_ready = 0;
    for (int i = 0; i < 5; i++) strobe(12'h100);
    do_reset();
    chk("dc_rst_level", 32'(level), 0);
    out_ready = 1;
    strobe(12'h100);
    chk("dc_rst_acc", 32'(out_data), 32'h1000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
